multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 The block SHALL have port op, input, 7 bits: opcode field of the instruction register.
REQ-004 The block SHALL have port funct3, input, 3 bits: funct3 field of the instruction register.
REQ-005 The block SHALL have port funct7, input, 1 bit: instruction bit 30.
REQ-006 The block SHALL have port Zero, input, 1 bit: ALU zero flag.
REQ-007 The block SHALL have port mem_ready, input, 1 bit: memory completes the current access this cycle.
REQ-008 The block SHALL have outputs PCWrite, AdrSrc, MemWrite, IRWrite and RegWrite, 1 bit each: datapath enables and selects.
REQ-009 The block SHALL have outputs ResultSrc, ALUSrcA, ALUSrcB and ImmSrc, 2 bits each: datapath selects.
REQ-010 The block SHALL have output ALUControl, 3 bits: ALU operation.
REQ-011 The block SHALL have output illegal, 1 bit: one-cycle pulse on an unsupported opcode.
REQ-012 Encodings SHALL be: ResultSrc 00=ALUOut, 01=Data, 10=ALUResult; ALUSrcA 00=PC, 01=OldPC, 10=RD1; ALUSrcB 00=RD2, 01=ImmExt, 10=4; AdrSrc 0=PC, 1=Result.

Function
REQ-013 The FSM SHALL have states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ and JAL; all outputs are decoded from the state, and PCWrite additionally from Zero in BEQ.
REQ-014 FETCH SHALL drive AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUControl=000, ResultSrc=10 and PCWrite=1, then go to DECODE.
REQ-015 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, ALUControl=000 (branch target); lw/sw go to MEMADR, R-type (0110011) to EXECR, I-ALU (0010011) to EXECI, beq (1100011) to BEQ, jal (1101111) to JAL.
REQ-016 On any other opcode, DECODE SHALL pulse illegal for one cycle and return to FETCH with no register or memory write.
REQ-017 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01, ALUControl=000; lw goes to MEMREAD, sw to MEMWRITE.
REQ-018 MEMREAD SHALL drive ResultSrc=00 and AdrSrc=1, then go to MEMWB.
REQ-019 MEMWB SHALL drive ResultSrc=01 and RegWrite=1, then go to FETCH.
REQ-020 MEMWRITE SHALL drive ResultSrc=00, AdrSrc=1 and MemWrite=1, then go to FETCH.
REQ-021 EXECR SHALL drive ALUSrcA=10 and ALUSrcB=00; EXECI SHALL drive ALUSrcA=10 and ALUSrcB=01; both go to ALUWB.
REQ-022 ALUWB SHALL drive ResultSrc=00 and RegWrite=1, then go to FETCH.
REQ-023 BEQ SHALL drive ALUSrcA=10, ALUSrcB=00, ALUControl=001, ResultSrc=00 and PCWrite=Zero, then go to FETCH.
REQ-024 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, ALUControl=000, ResultSrc=00 and PCWrite=1, then go to ALUWB.
REQ-025 In EXECR and EXECI, ALUControl SHALL follow funct3: 000 gives 001 if op[5] and funct7 are both 1, else 000; 010 gives 101; 110 gives 110; 111 gives 010; all other funct3 values give 000.
REQ-026 ImmSrc SHALL be 00 for lw and I-ALU, 01 for sw, 10 for beq and 11 for jal, for every state; for any other opcode it SHALL be 00.
REQ-027 Any output not listed for a state SHALL be 0 (selects 00).
REQ-028 Cycle counts SHALL be, with no wait states: lw 5, sw 4, R-type 4, I-ALU 4, beq 3, jal 4, illegal 2.

Reset
REQ-029 Asserting rst SHALL force the state to FETCH immediately, regardless of the clock, including mid-instruction.
REQ-030 While rst is high, PCWrite, IRWrite, RegWrite, MemWrite and illegal SHALL be 0; the other outputs SHALL take their FETCH values.
REQ-031 The first rising edge after rst falls SHALL execute FETCH.

Configuration
REQ-032 With the macro MULTICYCLE_CTRL_MEMWAIT_EN defined, FETCH, MEMREAD and MEMWRITE SHALL hold until mem_ready=1.
REQ-033 With MULTICYCLE_CTRL_MEMWAIT_EN defined, IRWrite and PCWrite in FETCH SHALL be gated by mem_ready, and MemWrite SHALL stay asserted until the cycle in which mem_ready=1.
REQ-034 Without MULTICYCLE_CTRL_MEMWAIT_EN, mem_ready SHALL be ignored and every memory access SHALL take one cycle.

Verification
REQ-035 lw (op=0000011) SHALL step FETCH, DECODE, MEMADR, MEMREAD, MEMWB, with RegWrite=1 and ResultSrc=01 only in cycle 5.
REQ-036 R-type sub (op=0110011, funct3=000, funct7=1) SHALL give ALUControl=001 in EXECR; with funct7=0, ALUControl=000; I-type addi with funct7=1 SHALL give 000.
REQ-037 beq SHALL give PCWrite=1 in its BEQ cycle when Zero=1 and PCWrite=0 when Zero=0, returning to FETCH in cycle 4 in both cases.
REQ-038 op=1111111 SHALL pulse illegal in DECODE and return to FETCH, with RegWrite and MemWrite 0 throughout.
REQ-039 rst asserted in the MEMWRITE cycle of sw SHALL drop MemWrite to 0 without waiting for a clock edge, and the first edge after release SHALL be FETCH.
REQ-040 With MULTICYCLE_CTRL_MEMWAIT_EN defined and mem_ready low for 3 cycles during sw, the block SHALL hold MEMWRITE with MemWrite=1 for 4 cycles and then go to FETCH.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle datapath (master) and its controller (slave).
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       illegal;

  modport master (
    output op, funct3, funct7, Zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal
  );

  modport slave (
    input  op, funct3, funct7, Zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 subset controller (lw/sw/R/I-ALU/beq/jal).
// Define MULTICYCLE_CTRL_MEMWAIT_EN to stall memory states until mem_ready.
module multicycle_ctrl (
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.slave   bus
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
  } state_t;

  state_t state_q, state_d;

  logic mem_done;
  logic op_legal;

`ifdef MULTICYCLE_CTRL_MEMWAIT_EN
  assign mem_done = bus.mem_ready;
`else
  // mem_ready is ignored: every access completes in a single cycle.
  assign mem_done = bus.mem_ready | 1'b1;
`endif

  assign op_legal = (bus.op == OP_LW) || (bus.op == OP_SW) || (bus.op == OP_R) ||
                    (bus.op == OP_I)  || (bus.op == OP_BEQ) || (bus.op == OP_JAL);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_done) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_done) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_done) state_d = S_FETCH;
      S_EXECR,
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  logic       pc_write_c, adr_src_c, mem_write_c, ir_write_c, reg_write_c, illegal_c;
  logic [1:0] result_src_c, alu_src_a_c, alu_src_b_c, imm_src_c;
  logic [2:0] alu_control_c, alu_decode_c;

  // ALU operation for EXECR/EXECI; sub needs op[5] so addi never subtracts.
  always_comb begin
    case (bus.funct3)
      3'b000:  alu_decode_c = (bus.op[5] && bus.funct7) ? 3'b001 : 3'b000;
      3'b010:  alu_decode_c = 3'b101;
      3'b110:  alu_decode_c = 3'b110;
      3'b111:  alu_decode_c = 3'b010;
      default: alu_decode_c = 3'b000;
    endcase
  end

  always_comb begin
    case (bus.op)
      OP_SW:   imm_src_c = 2'b01;
      OP_BEQ:  imm_src_c = 2'b10;
      OP_JAL:  imm_src_c = 2'b11;
      default: imm_src_c = 2'b00;
    endcase
  end

  // Output decode
  always_comb begin
    pc_write_c    = 1'b0;
    adr_src_c     = 1'b0;
    mem_write_c   = 1'b0;
    ir_write_c    = 1'b0;
    reg_write_c   = 1'b0;
    illegal_c     = 1'b0;
    result_src_c  = 2'b00;
    alu_src_a_c   = 2'b00;
    alu_src_b_c   = 2'b00;
    alu_control_c = 3'b000;
    case (state_q)
      S_FETCH: begin
        ir_write_c   = mem_done;
        pc_write_c   = mem_done;
        alu_src_b_c  = 2'b10;
        result_src_c = 2'b10;
      end
      S_DECODE: begin
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b01;
        illegal_c   = ~op_legal;
      end
      S_MEMADR: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
      end
      S_MEMREAD:  adr_src_c = 1'b1;
      S_MEMWB: begin
        result_src_c = 2'b01;
        reg_write_c  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_c   = 1'b1;
        mem_write_c = 1'b1;
      end
      S_EXECR: begin
        alu_src_a_c   = 2'b10;
        alu_control_c = alu_decode_c;
      end
      S_EXECI: begin
        alu_src_a_c   = 2'b10;
        alu_src_b_c   = 2'b01;
        alu_control_c = alu_decode_c;
      end
      S_ALUWB:    reg_write_c = 1'b1;
      S_BEQ: begin
        alu_src_a_c   = 2'b10;
        alu_control_c = 3'b001;
        pc_write_c    = bus.Zero;
      end
      S_JAL: begin
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b10;
        pc_write_c  = 1'b1;
      end
      default: ;
    endcase
  end

  // Write enables are forced low while reset is held; state is already FETCH.
  assign bus.PCWrite    = pc_write_c  & ~rst;
  assign bus.IRWrite    = ir_write_c  & ~rst;
  assign bus.RegWrite   = reg_write_c & ~rst;
  assign bus.MemWrite   = mem_write_c & ~rst;
  assign bus.illegal    = illegal_c   & ~rst;
  assign bus.AdrSrc     = adr_src_c;
  assign bus.ResultSrc  = result_src_c;
  assign bus.ALUSrcA    = alu_src_a_c;
  assign bus.ALUSrcB    = alu_src_b_c;
  assign bus.ImmSrc     = imm_src_c;
  assign bus.ALUControl = alu_control_c;

endmodule
